// File: rtl/mul_div_defs.sv
// Shared RV32M multiply/divide definitions: funct3 op codes, FSM states, widths.
// The control unit imports the same op constants.
package mul_div_defs;

  localparam int XLEN  = 32;
  localparam int ITER  = 32;
  localparam int CNT_W = 5;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Two's-complement magnitude, applied only when the operand is signed.
  function automatic logic [XLEN-1:0] abs_cond(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/mul_div_fsm.sv
// Sequencer for the iterative mul/div unit: state register, iteration counter,
// Busy/Done outputs and the load/iterate/fix strobes for the datapath.
module mul_div_fsm
  import mul_div_defs::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  output logic load_o,
  output logic iter_o,
  output logic fix_o,
  output logic busy_o,
  output logic done_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_CALC;
          cnt_d   = CNT_W'(ITER - 1);
        end
      end
      ST_CALC: begin
        // The 32nd iteration happens on the edge where the counter is 0.
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ST_CALC) || (state_d == ST_FIX);
      done_q  <= (state_d == ST_DONE);
    end
  end

  assign load_o = (state_q == ST_IDLE) && start_i;
  assign iter_o = (state_q == ST_CALC);
  assign fix_o  = (state_q == ST_FIX);
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, 34-cycle fixed latency from accepted Start_i to Done_o.
module mul_div_unit
  import mul_div_defs::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            Start_i,
  input  logic [2:0]      MulDiv_Operation_i,
  input  logic [XLEN-1:0] A_i,
  input  logic [XLEN-1:0] B_i,
  output logic            Busy_o,
  output logic            Done_o,
  output logic [XLEN-1:0] Result_o
);

  logic load, iter, fix;

  mul_div_fsm u_fsm (
    .clk     (clk),
    .reset   (reset),
    .start_i (Start_i),
    .load_o  (load),
    .iter_o  (iter),
    .fix_o   (fix),
    .busy_o  (Busy_o),
    .done_o  (Done_o)
  );

  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_mag_q, a_mag_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;
  logic              neg_q, neg_d;
  logic              div_zero_q, div_zero_d;
  logic              ovf_q, ovf_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_value;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (MulDiv_Operation_i)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  // Multiply: accumulator high half gains |A| when the current |B| bit is set.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);

  // Divide: dividend bits shift out of acc low half, quotient bits shift in.
  assign div_shift = {rem_q, acc_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, b_mag_q};

  always_comb begin
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix   = neg_q ? -rem_q : rem_q;
    fix_value = '0;
    case (op_q)
      OP_MUL:                        fix_value = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_value = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (div_zero_q)  fix_value = '1;
        else if (ovf_q)  fix_value = {1'b1, {(XLEN-1){1'b0}}};
        else             fix_value = quo_fix;
      end
      OP_REM, OP_REMU: begin
        if (div_zero_q)  fix_value = a_raw_q;
        else if (ovf_q)  fix_value = '0;
        else             fix_value = rem_fix;
      end
      default: fix_value = '0;
    endcase
  end

  always_comb begin
    op_d       = op_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    a_raw_d    = a_raw_q;
    neg_d      = neg_q;
    div_zero_d = div_zero_q;
    ovf_d      = ovf_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    result_d   = result_q;

    if (load) begin
      op_d       = MulDiv_Operation_i;
      a_mag_d    = abs_cond(A_i, a_signed);
      b_mag_d    = abs_cond(B_i, b_signed);
      a_raw_d    = A_i;
      div_zero_d = (B_i == '0);
      ovf_d      = (MulDiv_Operation_i == OP_DIV || MulDiv_Operation_i == OP_REM) &&
                   (A_i == {1'b1, {(XLEN-1){1'b0}}}) && (B_i == '1);
      rem_d      = '0;
      if (!MulDiv_Operation_i[2]) begin
        neg_d = (a_signed & A_i[XLEN-1]) ^ (b_signed & B_i[XLEN-1]);
        acc_d = {{XLEN{1'b0}}, abs_cond(B_i, b_signed)};
      end else begin
        case (MulDiv_Operation_i)
          OP_DIV:  neg_d = A_i[XLEN-1] ^ B_i[XLEN-1];
          OP_REM:  neg_d = A_i[XLEN-1];
          default: neg_d = 1'b0;
        endcase
        acc_d = {{XLEN{1'b0}}, abs_cond(A_i, a_signed)};
      end
    end else if (iter) begin
      if (!op_q[2]) begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
      end else begin
        acc_d[XLEN-1:0] = {acc_q[XLEN-2:0], div_ge};
        rem_d = div_ge ? XLEN'(div_shift - {1'b0, b_mag_q}) : div_shift[XLEN-1:0];
      end
    end else if (fix) begin
      result_d = fix_value;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= '0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      a_raw_q    <= '0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      acc_q      <= '0;
      rem_q      <= '0;
      result_q   <= '0;
    end else begin
      op_q       <= op_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      a_raw_q    <= a_raw_d;
      neg_q      <= neg_d;
      div_zero_q <= div_zero_d;
      ovf_q      <= ovf_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      result_q   <= result_d;
    end
  end

  assign Result_o = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: results, latency, busy window,
// Start_i ignored while busy, and asynchronous reset abort.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start_i;
  logic [2:0]  MulDiv_Operation_i;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic        Busy_o;
  logic        Done_o;
  logic [31:0] Result_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk                (clk),
    .reset              (reset),
    .Start_i            (Start_i),
    .MulDiv_Operation_i (MulDiv_Operation_i),
    .A_i                (A_i),
    .B_i                (B_i),
    .Busy_o             (Busy_o),
    .Done_o             (Done_o),
    .Result_o           (Result_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the unit idle. When disturb is set,
  // A_i/op are changed and Start_i pulsed during CALC.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit disturb);
    int          done_cyc = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] res      = 32'hDEAD_BEEF;
    logic [31:0] prev;
    prev               = Result_o;
    Start_i            = 1'b1;
    MulDiv_Operation_i = op;
    A_i                = a;
    B_i                = b;
    @(posedge clk); #1;
    Start_i = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (disturb && c == 5) begin
        A_i = 32'd0;
        MulDiv_Operation_i = 3'b000;
        Start_i = 1'b1;
      end
      if (disturb && c == 8) Start_i = 1'b0;
      if (c == 33) check({tag, "_hold"}, Result_o, prev);
      if (Busy_o) busy_cnt++;
      if (Done_o) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = c;
          res = Result_o;
        end
      end
      @(posedge clk); #1;
    end
    check({tag, "_result"}, res, exp);
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'd34);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_held"}, Result_o, exp);
    $display("op %s: op=%b a=%h b=%h result=%h expected=%h done@+%0d", tag, op, a, b, res, exp, done_cyc);
  endtask

  initial begin
    int dn;
    reset              = 1'b0;
    Start_i            = 1'b0;
    MulDiv_Operation_i = 3'b000;
    A_i                = '0;
    B_i                = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, Busy_o}, 32'd0);
    check("rst_done", {31'd0, Done_o}, 32'd0);
    check("rst_result", Result_o, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7_m3",      3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run_op("mulh_min",      3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
    run_op("mulhu_max",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("mulhsu_max",    3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div_m7_2",      3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
    run_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
    run_op("divu_big",      3'b101, 32'hFFFF_FFFE,  32'd2,         32'h7FFF_FFFF, 1'b0);
    run_op("remu_100_7",    3'b111, 32'd100,        32'd7,         32'd2,         1'b0);
    run_op("div_by0",       3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0);
    run_op("remu_by0",      3'b111, 32'd5,          32'd0,         32'd5,         1'b0);
    run_op("div_ovf",       3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("rem_ovf",       3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0);
    run_op("divu_disturb",  3'b101, 32'd100,        32'd7,         32'd14,        1'b1);

    // Abort a MUL with reset at T+10.
    Start_i            = 1'b1;
    MulDiv_Operation_i = 3'b000;
    A_i                = 32'd5;
    B_i                = 32'd6;
    @(posedge clk); #1;
    Start_i = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, Busy_o}, 32'd0);
    check("abort_done", {31'd0, Done_o}, 32'd0);
    check("abort_result", Result_o, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      if (Done_o) dn++;
      @(posedge clk); #1;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    $display("op abort: reset at T+10, done pulses after release=%0d", dn);

    run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
